titan_irq_controller: RTL and testbench

- Parametrised machine-level interrupt controller that feeds the core's external-interrupt input (MEIP).
- Collects NUM_SOURCES asynchronous interrupt lines and runs each through a per-source edge or level gateway.
- Arbitrates by programmable priority against a threshold, and exposes a claim/complete register handshake over a simple single-cycle register bus.
- Replaces the single hard-wired external interrupt line with N prioritised, maskable sources.

---
 rtl/titan_irq_pkg.sv | 18 +
 rtl/titan_irq_gateway.sv | 62 ++++++
 rtl/titan_irq_controller.sv | 147 ++++++++++++++
 tb/tb_titan_irq_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/titan_irq_pkg.sv
// Shared constants and types for the titan machine-level interrupt controller.
package titan_irq_pkg;

    localparam int ID_WIDTH = 5;
    typedef logic [ID_WIDTH-1:0] id_t;

    localparam logic [9:0] PRIO_BASE   = 10'h000;
    localparam logic [9:0] PENDING_OFS = 10'h080;
    localparam logic [9:0] ENABLE_OFS  = 10'h100;
    localparam logic [9:0] THRESH_OFS  = 10'h200;
    localparam logic [9:0] CLAIM_OFS   = 10'h204;

    // Byte address of the priority register for a given source ID.
    function automatic logic [9:0] prio_addr(input int id);
        return PRIO_BASE + 10'(id * 4);
    endfunction

endpackage

// File: rtl/titan_irq_gateway.sv
// Per-source gateway: input synchroniser, edge/level trigger, pending and in-service flags.
module titan_irq_gateway #(
    parameter bit EDGE        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic src_i,
    input  logic claim_i,
    input  logic complete_i,
    output logic pending_o
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_prev_r;
    logic                   pending_r;
    logic                   in_service_r;
    logic                   s_s;
    logic                   trig_s;
    logic                   set_s;

    assign s_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain plus delayed copy for rising-edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_r   <= {SYNC_STAGES{1'b0}};
            s_prev_r <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], src_i};
            s_prev_r <= s_s;
        end
    end

    // Trigger qualification: a source is only latched while idle.
    always_comb begin
        trig_s = EDGE ? (s_s & ~s_prev_r) : s_s;
        set_s  = trig_s & ~pending_r & ~in_service_r;
    end

    // Pending/in-service flags; a claim overrides a same-cycle trigger.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_r    <= 1'b0;
            in_service_r <= 1'b0;
        end else begin
            if (claim_i) begin
                pending_r <= 1'b0;
            end else if (set_s) begin
                pending_r <= 1'b1;
            end
            if (claim_i) begin
                in_service_r <= 1'b1;
            end else if (complete_i) begin
                in_service_r <= 1'b0;
            end
        end
    end

    assign pending_o = pending_r;

endmodule

// File: rtl/titan_irq_controller.sv
// Machine external interrupt controller: gateways, priority arbiter, register file and MEIP output.
module titan_irq_controller
    import titan_irq_pkg::*;
#(
    parameter int                     NUM_SOURCES = 8,
    parameter int                     PRIO_WIDTH  = 3,
    parameter logic [NUM_SOURCES-1:0] EDGE_MASK   = {NUM_SOURCES{1'b0}},
    parameter int                     SYNC_STAGES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_SOURCES-1:0] src_i,
    input  logic [9:0]             reg_addr_i,
    input  logic [31:0]            reg_wdata_i,
    input  logic                   reg_we_i,
    input  logic                   reg_re_i,
    output logic [31:0]            reg_rdata_o,
    output logic                   reg_ack_o,
    output logic                   meip_o
);

    logic [PRIO_WIDTH-1:0]  prio_r [NUM_SOURCES];
    logic [NUM_SOURCES-1:0] enable_r;
    logic [PRIO_WIDTH-1:0]  thresh_r;
    logic [31:0]            reg_rdata_r;
    logic                   reg_ack_r;
    logic                   meip_r;

    logic [NUM_SOURCES-1:0] pending_s;
    logic [NUM_SOURCES-1:0] claim_vec_s;
    logic [NUM_SOURCES-1:0] complete_vec_s;
    id_t                    best_id_s;
    logic [PRIO_WIDTH-1:0]  best_prio_s;
    logic [31:0]            rdata_s;
    logic                   rd_en_s;
    logic                   claim_s;
    logic                   complete_s;
    id_t                    cid_s;
    logic                   unused_wdata_s;

    // A write and read in the same cycle resolve to the write.
    assign rd_en_s        = reg_re_i & ~reg_we_i;
    assign claim_s        = rd_en_s & (reg_addr_i == CLAIM_OFS) & (best_id_s != {ID_WIDTH{1'b0}});
    assign complete_s     = reg_we_i & (reg_addr_i == CLAIM_OFS);
    assign cid_s          = reg_wdata_i[ID_WIDTH-1:0];
    assign unused_wdata_s = ^reg_wdata_i;

    for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_gw
        titan_irq_gateway #(
            .EDGE        (EDGE_MASK[g]),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_gw (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .src_i      (src_i[g]),
            .claim_i    (claim_vec_s[g]),
            .complete_i (complete_vec_s[g]),
            .pending_o  (pending_s[g])
        );
    end

    // Priority arbiter: strict greater-than on ascending IDs keeps the lowest ID on ties.
    always_comb begin
        best_id_s   = {ID_WIDTH{1'b0}};
        best_prio_s = {PRIO_WIDTH{1'b0}};
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (pending_s[i] && enable_r[i] && (prio_r[i] > thresh_r) && (prio_r[i] > best_prio_s)) begin
                best_id_s   = id_t'(i + 1);
                best_prio_s = prio_r[i];
            end else begin
                best_id_s   = best_id_s;
                best_prio_s = best_prio_s;
            end
        end
    end

    // Per-source claim and complete strobes decoded from the bus.
    always_comb begin
        claim_vec_s    = {NUM_SOURCES{1'b0}};
        complete_vec_s = {NUM_SOURCES{1'b0}};
        for (int i = 0; i < NUM_SOURCES; i++) begin
            claim_vec_s[i]    = claim_s & (best_id_s == id_t'(i + 1));
            complete_vec_s[i] = complete_s & (cid_s == id_t'(i + 1));
        end
    end

    // Read data mux; bit 0 of pending/enable is the reserved ID 0.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (reg_addr_i)
            PENDING_OFS: rdata_s = 32'({pending_s, 1'b0});
            ENABLE_OFS:  rdata_s = 32'({enable_r, 1'b0});
            THRESH_OFS:  rdata_s = 32'(thresh_r);
            CLAIM_OFS:   rdata_s = 32'(best_id_s);
            default: begin
                for (int i = 0; i < NUM_SOURCES; i++) begin
                    if (reg_addr_i == prio_addr(i + 1)) begin
                        rdata_s = 32'(prio_r[i]);
                    end else begin
                        rdata_s = rdata_s;
                    end
                end
            end
        endcase
    end

    // Configuration registers: priority, enable, threshold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_SOURCES; i++) begin
                prio_r[i] <= {PRIO_WIDTH{1'b0}};
            end
            enable_r <= {NUM_SOURCES{1'b0}};
            thresh_r <= {PRIO_WIDTH{1'b0}};
        end else if (reg_we_i) begin
            for (int i = 0; i < NUM_SOURCES; i++) begin
                if (reg_addr_i == prio_addr(i + 1)) begin
                    prio_r[i] <= reg_wdata_i[PRIO_WIDTH-1:0];
                end
            end
            if (reg_addr_i == ENABLE_OFS) begin
                enable_r <= reg_wdata_i[NUM_SOURCES:1];
            end
            if (reg_addr_i == THRESH_OFS) begin
                thresh_r <= reg_wdata_i[PRIO_WIDTH-1:0];
            end
        end
    end

    // Registered bus response and interrupt output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_ack_r   <= 1'b0;
            reg_rdata_r <= 32'h0000_0000;
            meip_r      <= 1'b0;
        end else begin
            reg_ack_r   <= reg_we_i | reg_re_i;
            reg_rdata_r <= rd_en_s ? rdata_s : 32'h0000_0000;
            meip_r      <= (best_id_s != {ID_WIDTH{1'b0}});
        end
    end

    assign reg_ack_o   = reg_ack_r;
    assign reg_rdata_o = reg_rdata_r;
    assign meip_o      = meip_r;

endmodule

// File: tb/tb_titan_irq_controller.sv
// Bench for titan_irq_controller: directed scenarios plus randomized traffic against a behavioural model.
module tb_titan_irq_controller;

    localparam int          N  = 8;
    localparam int          PW = 3;
    localparam int          SS = 2;
    localparam logic [N-1:0] EM = 8'b0000_0010;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [N-1:0] src_i = '0;
    logic [9:0]   reg_addr_i = '0;
    logic [31:0]  reg_wdata_i = '0;
    logic         reg_we_i = 1'b0;
    logic         reg_re_i = 1'b0;
    logic [31:0]  reg_rdata_o;
    logic         reg_ack_o;
    logic         meip_o;

    int tests = 0;
    int fails = 0;

    titan_irq_controller #(
        .NUM_SOURCES (N),
        .PRIO_WIDTH  (PW),
        .EDGE_MASK   (EM),
        .SYNC_STAGES (SS)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .src_i       (src_i),
        .reg_addr_i  (reg_addr_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_we_i    (reg_we_i),
        .reg_re_i    (reg_re_i),
        .reg_rdata_o (reg_rdata_o),
        .reg_ack_o   (reg_ack_o),
        .meip_o      (meip_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural model state, indexed by source ID.
    logic [PW-1:0] m_prio [1:N];
    logic [N:1]    m_pend, m_insvc, m_en;
    logic [PW-1:0] m_thr;
    logic [N-1:0]  m_hist [$];
    logic          m_ack, m_meip;
    logic [31:0]   m_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int id = 1; id <= N; id++) m_prio[id] = '0;
        m_pend = '0; m_insvc = '0; m_en = '0; m_thr = '0;
        m_ack = 1'b0; m_rdata = '0; m_meip = 1'b0;
        m_hist.delete();
        repeat (SS + 1) m_hist.push_back('0);
    endtask

    // Highest priority above threshold wins, lowest ID first within a level.
    function automatic int m_best();
        for (int p = (1 << PW) - 1; p > int'(m_thr); p--)
            for (int id = 1; id <= N; id++)
                if (m_pend[id] && m_en[id] && int'(m_prio[id]) == p) return id;
        return 0;
    endfunction

    function automatic logic [31:0] m_read(input int a, input int best);
        if (a >= 4 && a <= 4 * N && a % 4 == 0) return 32'(m_prio[a / 4]);
        case (a)
            'h080:   return 32'({m_pend, 1'b0});
            'h100:   return 32'({m_en, 1'b0});
            'h200:   return 32'(m_thr);
            'h204:   return 32'(best);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        int best, a, c;
        logic [N-1:0] s, sp;
        logic [N:1] np, ni;
        logic rd, trig;
        best = m_best();
        s  = m_hist[SS - 1];
        sp = m_hist[SS];
        rd = reg_re_i && !reg_we_i;
        a  = int'(reg_addr_i);
        m_ack   = reg_we_i || reg_re_i;
        m_rdata = rd ? m_read(a, best) : 32'h0;
        m_meip  = (best != 0);
        np = m_pend; ni = m_insvc;
        for (int id = 1; id <= N; id++) begin
            trig = EM[id-1] ? (s[id-1] && !sp[id-1]) : s[id-1];
            if (trig && !m_pend[id] && !m_insvc[id]) np[id] = 1'b1;
        end
        if (rd && a == 'h204 && best != 0) begin
            np[best] = 1'b0;
            ni[best] = 1'b1;
        end
        if (reg_we_i) begin
            if (a >= 4 && a <= 4 * N && a % 4 == 0) m_prio[a / 4] = reg_wdata_i[PW-1:0];
            if (a == 'h100) m_en = reg_wdata_i[N:1];
            if (a == 'h200) m_thr = reg_wdata_i[PW-1:0];
            if (a == 'h204) begin
                c = int'(reg_wdata_i[4:0]);
                if (c >= 1 && c <= N && m_insvc[c]) ni[c] = 1'b0;
            end
        end
        m_pend = np; m_insvc = ni;
        m_hist.push_front(src_i);
        void'(m_hist.pop_back());
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it.
    task automatic step(input logic we, input logic re, input logic [9:0] addr, input logic [31:0] wd);
        reg_we_i = we; reg_re_i = re; reg_addr_i = addr; reg_wdata_i = wd;
        @(posedge clk_i);
        if (rst_i) model_reset(); else model_step();
        #1;
        check("ack", 32'(reg_ack_o), 32'(m_ack));
        check("rdata", reg_rdata_o, m_rdata);
        check("meip", 32'(meip_o), 32'(m_meip));
        reg_we_i = 1'b0; reg_re_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 10'h000, 32'h0);
    endtask

    task automatic wr(input logic [9:0] addr, input logic [31:0] wd);
        step(1'b1, 1'b0, addr, wd);
    endtask

    task automatic rd(input logic [9:0] addr, output logic [31:0] d);
        step(1'b0, 1'b1, addr, 32'h0);
        d = reg_rdata_o;
    endtask

    task automatic pulse2();
        src_i[1] = 1'b1; idle(2);
        src_i[1] = 1'b0; idle(2);
    endtask

    logic [9:0] addr_tbl [16] = '{10'h000, 10'h004, 10'h008, 10'h00C, 10'h010, 10'h014,
                                  10'h018, 10'h01C, 10'h020, 10'h024, 10'h080, 10'h100,
                                  10'h200, 10'h204, 10'h204, 10'h3FC};

    initial begin
        logic [31:0] d;
        logic [9:0]  ra;
        logic [31:0] rw;
        model_reset();
        idle(2);
        rst_i = 1'b0;

        // Reset state and ack timing
        rd(10'h080, d); check("rst_pending", d, 32'h0);
        rd(10'h100, d); check("rst_enable", d, 32'h0);
        rd(10'h200, d); check("rst_thresh", d, 32'h0);
        rd(10'h204, d); check("rst_claim", d, 32'h0);
        check("rst_meip", 32'(meip_o), 32'h0);
        idle(1);
        check("ack_one_cycle", 32'(reg_ack_o), 32'h0);

        // Level source 3: latency, claim, complete with line still high
        wr(10'h00C, 32'd5); wr(10'h200, 32'd2); wr(10'h100, 32'h8);
        src_i[2] = 1'b1;
        idle(SS + 1); check("lvl_meip_early", 32'(meip_o), 32'h0);
        idle(1);      check("lvl_meip_on", 32'(meip_o), 32'h1);
        rd(10'h204, d); check("lvl_claim", d, 32'd3);
        idle(1);      check("lvl_meip_off", 32'(meip_o), 32'h0);
        wr(10'h204, 32'hFFFF_FFE3);
        idle(2);      check("lvl_repend_meip", 32'(meip_o), 32'h1);
        rd(10'h204, d); check("lvl_claim2", d, 32'd3);
        src_i[2] = 1'b0; idle(SS + 2);
        wr(10'h204, 32'd3); idle(2);
        rd(10'h080, d); check("lvl_clear", d, 32'h0);

        // Equal priority tie, then higher priority on the larger ID
        wr(10'h004, 32'd4); wr(10'h010, 32'd4); wr(10'h100, 32'h1A);
        src_i = 8'b0000_1001; idle(SS + 2);
        rd(10'h204, d); check("tie_first", d, 32'd1);
        rd(10'h204, d); check("tie_second", d, 32'd4);
        src_i = '0; idle(SS + 2);
        wr(10'h204, 32'd1); wr(10'h204, 32'd4);
        wr(10'h010, 32'd6);
        src_i = 8'b0000_1001; idle(SS + 2);
        rd(10'h204, d); check("prio_first", d, 32'd4);
        rd(10'h204, d); check("prio_second", d, 32'd1);
        src_i = '0; idle(SS + 2);
        wr(10'h204, 32'd1); wr(10'h204, 32'd4);

        // Edge source 2: pulses while in service are dropped
        wr(10'h008, 32'd5); wr(10'h100, 32'h1E);
        pulse2(); idle(SS + 1);
        rd(10'h204, d); check("edge_claim", d, 32'd2);
        pulse2(); pulse2(); idle(SS + 2);
        rd(10'h204, d); check("edge_dropped", d, 32'd0);
        rd(10'h080, d); check("edge_no_pend", d, 32'h0);
        wr(10'h204, 32'd2);
        pulse2(); idle(SS + 2);
        rd(10'h080, d); check("edge_repend", d, 32'h4);
        rd(10'h204, d); check("edge_claim2", d, 32'd2);
        wr(10'h204, 32'd2);

        // Threshold equal to priority blocks the source
        wr(10'h014, 32'd3); wr(10'h200, 32'd3); wr(10'h100, 32'h3E);
        src_i[4] = 1'b1; idle(SS + 2);
        check("thr_meip_off", 32'(meip_o), 32'h0);
        rd(10'h204, d); check("thr_claim_none", d, 32'd0);
        wr(10'h200, 32'd2); idle(1);
        check("thr_meip_on", 32'(meip_o), 32'h1);
        rd(10'h204, d); check("thr_claim", d, 32'd5);
        src_i[4] = 1'b0; idle(SS + 2);
        wr(10'h204, 32'd5);

        // Invalid completes leave source 3 in service
        src_i[2] = 1'b1; idle(SS + 2);
        rd(10'h204, d); check("inv_claim", d, 32'd3);
        wr(10'h204, 32'd0); wr(10'h204, 32'd9); wr(10'h204, 32'd5);
        idle(3);
        rd(10'h080, d); check("inv_pending", d, 32'h0);
        check("inv_meip", 32'(meip_o), 32'h0);
        wr(10'h204, 32'd3); idle(2);
        rd(10'h080, d); check("inv_repend", d, 32'h8);

        // Reset during a claim strobe suppresses the ack and clears state
        rst_i = 1'b1; src_i = '0;
        step(1'b0, 1'b1, 10'h204, 32'h0);
        check("rst_mid_ack", 32'(reg_ack_o), 32'h0);
        rst_i = 1'b0; idle(1);
        rd(10'h080, d); check("post_rst_pending", d, 32'h0);
        rd(10'h100, d); check("post_rst_enable", d, 32'h0);
        rd(10'h200, d); check("post_rst_thresh", d, 32'h0);
        rd(10'h00C, d); check("post_rst_prio3", d, 32'h0);

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) src_i[b] = ~src_i[b];
            rst_i = ($urandom_range(0, 499) == 0);
            ra = addr_tbl[$urandom_range(0, 15)];
            rw = $urandom;
            if (ra == 10'h204) rw[4:0] = 5'($urandom_range(0, 12));
            case ($urandom_range(0, 5))
                0:       step(1'b1, 1'b0, ra, rw);
                1, 2:    step(1'b0, 1'b1, ra, rw);
                3:       step(1'b1, 1'b1, ra, rw);
                default: step(1'b0, 1'b0, ra, rw);
            endcase
        end
        rst_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
